sram_ctrl_1p1024x39: RTL and testbench
======================================

# sram_ctrl_1p1024x39

Controller that owns one single-port 1024x39 SRAM macro instance (32 data + 7 ECC bits per word) and shares it between two requesters: A (bus host) and B (background scrubber/DMA). It optionally zero-fills the whole array after reset. It then round-robin arbitrates single-beat read and write accesses and returns read data with fixed one-cycle latency. It sits between the integrity-protected bus adapters and the raw SRAM macro.

## Interface
Parameters:
- Depth, 1024, number of words; power of two.
- Width, 39, word width in bits.
- AddrW, $clog2(Depth), address width; derived, not overridden.
- InitData, '0 (Width bits), word written to every location during init.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- a_req_i / b_req_i  in  1  access request; held with its payload until granted.
- a_write_i / b_write_i  in  1  1 = write, 0 = read.
- a_addr_i / b_addr_i  in  AddrW  word address.
- a_wdata_i / b_wdata_i  in  Width  write data.
- a_gnt_o / b_gnt_o  out  1  combinational grant; the access executes this cycle.
- a_rvalid_o / b_rvalid_o  out  1  read data valid, one cycle after a read grant.
- a_rdata_o / b_rdata_o  out  Width  read data; both driven from sram_rdata_i.
- sram_req_o, sram_write_o, sram_wmask_o  out  1  macro controls.
- sram_addr_o  out  AddrW  macro address.
- sram_wdata_o  out  Width  macro write data.
- sram_rdata_i  in  Width  macro read data; registered in the macro, valid one cycle after a read request.
- init_done_o  out  1  array initialised; requests are accepted.

## Operation
- State machine with two states: INIT and READY. Reset enters INIT when the init feature is compiled in, otherwise READY.
- INIT:
  - A 10-bit counter runs 0..Depth-1.
  - Each cycle: sram_req_o=1, sram_write_o=1, sram_wmask_o=1, sram_addr_o=counter, sram_wdata_o=InitData.
  - After the write at Depth-1, the block moves to READY.
  - No grants are issued; requests stay pending.
- READY, arbitration:
  - Only one requester active: it is granted.
  - Both active: the requester not granted most recently wins.
  - last_gnt flop resets to B, so A wins the first tie.
  - last_gnt updates only on a grant.
- READY, granted access:
  - The selected port's payload drives the macro, sram_req_o=1, sram_wmask_o=1.
  - With no grant, sram_req_o=0 and the other macro outputs are don't-care (held at 0).
- Reads: the registered flags rd_a/rd_b are set for the read-granted port. Next cycle, that port's rvalid_o=1 and its rdata_o = sram_rdata_i.
- Writes produce no response; gnt is the completion.
- A requester may be granted every cycle (back-to-back, full throughput).

## Timing
- Reset values:
  - gnt, rvalid, sram_req_o, sram_write_o, sram_wmask_o: 0.
  - sram_addr_o, sram_wdata_o: 0.
  - Counter 0, last_gnt = B.
  - init_done_o: 0 with init, 1 without.
- Init takes exactly Depth cycles after reset release. init_done_o rises in cycle Depth; the first grant is possible in that same cycle.
- Read latency is 1 cycle from grant to rvalid.
- Write then read of the same address in consecutive cycles returns the new data, because the macro is single-port and sequential.
- Simultaneous read of B and write of A to the same address: the winner executes first; the loser sees its result.
- Reset asserted mid-init or mid-read: all outputs return to reset values asynchronously, a pending rvalid is dropped, and init restarts from address 0.

## Configuration
- SRAM_CTRL_INIT_EN defined:
  - INIT state and counter are present.
  - init_done_o is 0 for the Depth cycles after reset.
  - The array reads InitData everywhere after init.
- SRAM_CTRL_INIT_EN undefined:
  - No counter; the block starts in READY and init_done_o is tied to 1.
  - Array contents after reset are undefined.
  - Grants are possible in the first cycle after reset.

## Structure
- Package sram_ctrl_pkg:
  - sram_ctrl_state_e {INIT, READY}.
  - requester index enum {REQ_A, REQ_B}.
  - Constants SramDepth=1024, SramWidth=39, SramAddrW=10.
- Sub-module sram_ctrl_rr_arb: 2-way round-robin arbiter, with req[1:0] and an enable in, gnt[1:0] out, holding the last_gnt flop.
- The macro is instantiated by the parent, not inside this block.

## Test plan
- Reset with SRAM_CTRL_INIT_EN: init_done_o low for 1024 cycles, sram writes of 0 to addresses 0..1023 in order. Reading address 0x3FF afterwards returns 39'h0.
- A writes 39'h7F_1234_5678 to 0x010, then reads 0x010: a_gnt_o pulses both cycles; a_rvalid_o=1 exactly one cycle after the read grant with that data.
- A and B both request continuously: grants alternate A, B, A, B…, with no idle cycle.
- Requests raised during init: no grant until init_done_o=1. Both requests are then served A first, then B.
- rst_ni pulled low at init count 500 and while a B read is in flight: b_rvalid_o is never asserted. Init restarts at address 0 and completes 1024 cycles after release.
- Without the macro: grant in the first post-reset cycle and init_done_o=1 from reset.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 1024x39 single-port SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned SramDepth = 1024;
  localparam int unsigned SramWidth = 39;
  localparam int unsigned SramAddrW = 10;

  typedef enum logic {
    StInit,
    StReady
  } sram_ctrl_state_e;

  typedef enum logic {
    ReqA,
    ReqB
  } sram_ctrl_req_e;

endpackage

// File: rtl/sram_ctrl_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester not granted most recently wins.
module sram_ctrl_rr_arb
  import sram_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  sram_ctrl_req_e last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (last_q == ReqB) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
    if (gnt_o[0]) begin
      last_d = ReqA;
    end else if (gnt_o[1]) begin
      last_d = ReqB;
    end
  end

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= ReqB;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_ctrl_1p1024x39.sv
// Two-requester controller for a single-port 1024x39 SRAM macro.
// Optional post-reset zero-fill is compiled in with SRAM_CTRL_INIT_EN.
module sram_ctrl_1p1024x39
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned          Depth    = SramDepth,
  parameter int unsigned          Width    = SramWidth,
  localparam int unsigned         AddrW    = $clog2(Depth),
  parameter logic [Width-1:0]     InitData = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  input  logic             a_write_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  output logic             a_gnt_o,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  input  logic             b_req_i,
  input  logic             b_write_i,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  output logic             b_gnt_o,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             sram_req_o,
  output logic             sram_write_o,
  output logic             sram_wmask_o,
  output logic [AddrW-1:0] sram_addr_o,
  output logic [Width-1:0] sram_wdata_o,
  input  logic [Width-1:0] sram_rdata_i,
  output logic             init_done_o
);

  sram_ctrl_state_e state_q;
  logic [AddrW-1:0] init_addr;
  logic             ready;
  logic [1:0]       gnt;
  logic             rd_a_q, rd_a_d, rd_b_q, rd_b_d;

`ifdef SRAM_CTRL_INIT_EN
  sram_ctrl_state_e state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AddrW'(Depth - 1)) begin
        state_d = StReady;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_addr = cnt_q;
`else
  assign state_q   = StReady;
  assign init_addr = '0;
`endif

  assign ready       = (state_q == StReady);
  assign init_done_o = ready;

  // Gating with rst_ni keeps grants and macro strobes at zero while reset is held.
  sram_ctrl_rr_arb u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (ready & rst_ni),
    .req_i  ({b_req_i, a_req_i}),
    .gnt_o  (gnt)
  );

  assign a_gnt_o = gnt[0];
  assign b_gnt_o = gnt[1];

  always_comb begin
    sram_req_o   = 1'b0;
    sram_write_o = 1'b0;
    sram_wmask_o = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (!ready) begin
      sram_req_o   = rst_ni;
      sram_write_o = rst_ni;
      sram_wmask_o = rst_ni;
      sram_addr_o  = init_addr;
      sram_wdata_o = rst_ni ? InitData : '0;
    end else if (gnt[0]) begin
      sram_req_o   = 1'b1;
      sram_write_o = a_write_i;
      sram_wmask_o = 1'b1;
      sram_addr_o  = a_addr_i;
      sram_wdata_o = a_wdata_i;
    end else if (gnt[1]) begin
      sram_req_o   = 1'b1;
      sram_write_o = b_write_i;
      sram_wmask_o = 1'b1;
      sram_addr_o  = b_addr_i;
      sram_wdata_o = b_wdata_i;
    end
  end

  always_comb begin
    rd_a_d = gnt[0] & ~a_write_i;
    rd_b_d = gnt[1] & ~b_write_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_a_q <= 1'b0;
      rd_b_q <= 1'b0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign a_rvalid_o = rd_a_q;
  assign b_rvalid_o = rd_b_q;
  assign a_rdata_o  = sram_rdata_i;
  assign b_rdata_o  = sram_rdata_i;

endmodule

// File: tb/tb_sram_ctrl_1p1024x39.sv
// Scoreboard bench for sram_ctrl_1p1024x39 with a behavioural single-port macro.
module tb_sram_ctrl_1p1024x39;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Width = 39;
  localparam int unsigned AddrW = 10;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             a_req, a_write, b_req, b_write;
  logic [AddrW-1:0] a_addr, b_addr;
  logic [Width-1:0] a_wdata, b_wdata;
  logic             a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o;
  logic [Width-1:0] a_rdata_o, b_rdata_o;
  logic             sram_req_o, sram_write_o, sram_wmask_o;
  logic [AddrW-1:0] sram_addr_o;
  logic [Width-1:0] sram_wdata_o, sram_rdata;
  logic             init_done_o;

  always #5 clk = ~clk;

  sram_ctrl_1p1024x39 dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .a_req_i      (a_req),
    .a_write_i    (a_write),
    .a_addr_i     (a_addr),
    .a_wdata_i    (a_wdata),
    .a_gnt_o      (a_gnt_o),
    .a_rvalid_o   (a_rvalid_o),
    .a_rdata_o    (a_rdata_o),
    .b_req_i      (b_req),
    .b_write_i    (b_write),
    .b_addr_i     (b_addr),
    .b_wdata_i    (b_wdata),
    .b_gnt_o      (b_gnt_o),
    .b_rvalid_o   (b_rvalid_o),
    .b_rdata_o    (b_rdata_o),
    .sram_req_o   (sram_req_o),
    .sram_write_o (sram_write_o),
    .sram_wmask_o (sram_wmask_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata),
    .init_done_o  (init_done_o)
  );

  // Behavioural macro: registered read, write when req & write & wmask.
  logic [Width-1:0] mem [Depth];
  always @(posedge clk) begin
    if (sram_req_o) begin
      if (sram_write_o) begin
        if (sram_wmask_o) mem[sram_addr_o] <= sram_wdata_o;
      end else begin
        sram_rdata <= mem[sram_addr_o];
      end
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [Width-1:0] data;
    int unsigned      due;
  } exp_t;

  exp_t             qa[$], qb[$];
  exp_t             mon_a, mon_b;
  logic [Width-1:0] ref_mem [Depth];
  logic             exp_last_b;
  logic [1:0]       g;

  // Arbitration model: returns {b, a} grant and tracks who won last.
  function automatic logic [1:0] exp_winner(input logic ra, input logic rb);
    logic [1:0] r;
    if (ra && rb) r = exp_last_b ? 2'b01 : 2'b10;
    else r = {rb, ra};
    if (r[0]) exp_last_b = 1'b0;
    else if (r[1]) exp_last_b = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_write = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_write = 0; b_addr = '0; b_wdata = '0;
  endtask

  // Apply observed grants to the reference memory / read scoreboard.
  task automatic record_grants();
    if (a_gnt_o) begin
      if (a_write) ref_mem[a_addr] = a_wdata;
      else qa.push_back('{data: ref_mem[a_addr], due: cyc + 1});
    end
    if (b_gnt_o) begin
      if (b_write) ref_mem[b_addr] = b_wdata;
      else qb.push_back('{data: ref_mem[b_addr], due: cyc + 1});
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (a_rvalid_o) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_rvalid_unexpected: got rvalid data=%h, required no rvalid", a_rdata_o);
        end else begin
          mon_a = qa.pop_front();
          if (mon_a.due != cyc || a_rdata_o !== mon_a.data) begin
            errors++;
            $display("FAIL a_rdata: got %h at cycle %0d, required %h at cycle %0d",
                     a_rdata_o, cyc, mon_a.data, mon_a.due);
          end
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL a_rvalid_missing: got 0, required rvalid with %h", qa[0].data);
        void'(qa.pop_front());
      end
      if (b_rvalid_o) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_rvalid_unexpected: got rvalid data=%h, required no rvalid", b_rdata_o);
        end else begin
          mon_b = qb.pop_front();
          if (mon_b.due != cyc || b_rdata_o !== mon_b.data) begin
            errors++;
            $display("FAIL b_rdata: got %h at cycle %0d, required %h at cycle %0d",
                     b_rdata_o, cyc, mon_b.data, mon_b.due);
          end
        end
      end else if (qb.size() != 0 && qb[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL b_rvalid_missing: got 0, required rvalid with %h", qb[0].data);
        void'(qb.pop_front());
      end
    end
  end

  task automatic test_reset();
    logic exp_done;
`ifdef SRAM_CTRL_INIT_EN
    exp_done = 1'b0;
`else
    exp_done = 1'b1;
`endif
    rst_ni = 0;
    a_req = 1; b_req = 1; a_addr = 10'h155; b_addr = 10'h2AA;
    @(negedge clk);
    checks++;
    if ({a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, sram_req_o, sram_write_o, sram_wmask_o}
        !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b%b rv=%b%b sram=%b%b%b, required all 0",
               a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, sram_req_o, sram_write_o,
               sram_wmask_o);
    end
    checks++;
    if (sram_addr_o !== '0 || sram_wdata_o !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h, required 0/0", sram_addr_o, sram_wdata_o);
    end
    checks++;
    if (init_done_o !== exp_done) begin
      errors++;
      $display("FAIL reset_init_done: got %b, required %b", init_done_o, exp_done);
    end
    idle_inputs();
    qa.delete(); qb.delete();
    exp_last_b = 1'b1;
  endtask

`ifdef SRAM_CTRL_INIT_EN
  task automatic test_init();
    for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
    a_req = 1; a_write = 0; a_addr = 10'h3FF;
    b_req = 1; b_write = 0; b_addr = 10'h005;
    @(posedge clk); #1;
    rst_ni = 1;
    for (int i = 0; i < Depth; i++) begin
      @(negedge clk);
      checks++;
      if (init_done_o !== 1'b0 || sram_req_o !== 1'b1 || sram_write_o !== 1'b1 ||
          sram_wmask_o !== 1'b1 || sram_addr_o !== AddrW'(i) || sram_wdata_o !== '0 ||
          a_gnt_o !== 1'b0 || b_gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL init_write %0d: got done=%b req=%b we=%b addr=%h wd=%h gnt=%b%b",
                 i, init_done_o, sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o,
                 a_gnt_o, b_gnt_o);
      end
    end
    @(negedge clk);
    g = exp_winner(1'b1, 1'b1);
    checks++;
    if (init_done_o !== 1'b1 || {b_gnt_o, a_gnt_o} !== g) begin
      errors++;
      $display("FAIL init_first_gnt: got done=%b gnt(b,a)=%b%b, required 1 and %b",
               init_done_o, b_gnt_o, a_gnt_o, g);
    end
    record_grants();
    step();
    a_req = 0;
    @(negedge clk);
    g = exp_winner(1'b0, 1'b1);
    checks++;
    if ({b_gnt_o, a_gnt_o} !== g) begin
      errors++;
      $display("FAIL init_second_gnt: got gnt(b,a)=%b%b, required %b", b_gnt_o, a_gnt_o, g);
    end
    record_grants();
    step();
    idle_inputs();
    repeat (2) step();
  endtask
`else
  task automatic test_no_init();
    a_req = 1; a_write = 1; a_addr = 10'h020; a_wdata = 39'h12_3456_789A;
    @(posedge clk); #1;
    rst_ni = 1;
    @(negedge clk);
    g = exp_winner(1'b1, 1'b0);
    checks++;
    if (init_done_o !== 1'b1 || {b_gnt_o, a_gnt_o} !== g) begin
      errors++;
      $display("FAIL no_init_first_gnt: got done=%b gnt(b,a)=%b%b, required 1 and %b",
               init_done_o, b_gnt_o, a_gnt_o, g);
    end
    record_grants();
    step();
    idle_inputs();
  endtask
`endif

  task automatic test_write_read();
    a_req = 1; a_write = 1; a_addr = 10'h010; a_wdata = 39'h7F_1234_5678;
    @(negedge clk);
    g = exp_winner(1'b1, 1'b0);
    checks++;
    if ({b_gnt_o, a_gnt_o} !== g || sram_write_o !== 1'b1 || sram_wmask_o !== 1'b1 ||
        sram_addr_o !== 10'h010 || sram_wdata_o !== 39'h7F_1234_5678) begin
      errors++;
      $display("FAIL wr_gnt: got gnt(b,a)=%b%b we=%b addr=%h wd=%h, required %b 1 010 7f12345678",
               b_gnt_o, a_gnt_o, sram_write_o, sram_addr_o, sram_wdata_o, g);
    end
    record_grants();
    step();
    a_write = 0;
    @(negedge clk);
    g = exp_winner(1'b1, 1'b0);
    checks++;
    if ({b_gnt_o, a_gnt_o} !== g || sram_write_o !== 1'b0 || a_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_gnt: got gnt(b,a)=%b%b we=%b rvalid=%b, required %b 0 0",
               b_gnt_o, a_gnt_o, sram_write_o, a_rvalid_o, g);
    end
    record_grants();
    step();
    a_req = 0;
    @(negedge clk);
    checks++;
    if (a_rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency: got a_rvalid=%b one cycle after grant, required 1", a_rvalid_o);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int j = 0;
    int k = 0;
    a_req = 1; a_write = 0; a_addr = 10'h010;
    b_req = 1; b_write = 1; b_addr = 10'h100; b_wdata = {7'h5A, $urandom()};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      g = exp_winner(1'b1, 1'b1);
      checks++;
      if ({b_gnt_o, a_gnt_o} !== g) begin
        errors++;
        $display("FAIL b2b_gnt %0d: got gnt(b,a)=%b%b, required %b", c, b_gnt_o, a_gnt_o, g);
      end
      record_grants();
      step();
      if (g[0]) begin
        j++;
        a_addr = AddrW'(10'h100 + j - 1);
      end
      if (g[1]) begin
        k++;
        b_addr  = AddrW'(10'h100 + k);
        b_wdata = {7'(k), $urandom()};
      end
    end
    idle_inputs();
    repeat (2) step();
  endtask

  task automatic test_collision();
    logic done_a, done_b;
    b_req = 1; b_write = 1; b_addr = 10'h200; b_wdata = 39'h01_1111_1111;
    @(negedge clk);
    g = exp_winner(1'b0, 1'b1);
    checks++;
    if ({b_gnt_o, a_gnt_o} !== g) begin
      errors++;
      $display("FAIL coll_prewrite: got gnt(b,a)=%b%b, required %b", b_gnt_o, a_gnt_o, g);
    end
    record_grants();
    step();
    a_req = 1; a_write = 1; a_addr = 10'h200; a_wdata = 39'h7E_EEEE_EEEE;
    b_req = 1; b_write = 0;
    done_a = 0; done_b = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      g = exp_winner(!done_a, !done_b);
      checks++;
      if ({b_gnt_o, a_gnt_o} !== g) begin
        errors++;
        $display("FAIL coll_gnt %0d: got gnt(b,a)=%b%b, required %b", c, b_gnt_o, a_gnt_o, g);
      end
      record_grants();
      step();
      if (g[0]) begin done_a = 1; a_req = 0; end
      if (g[1]) begin done_b = 1; b_req = 0; end
    end
    idle_inputs();
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    b_req = 1; b_write = 0; b_addr = 10'h010;
    @(negedge clk);
    g = exp_winner(1'b0, 1'b1);
    checks++;
    if ({b_gnt_o, a_gnt_o} !== g) begin
      errors++;
      $display("FAIL mid_rd_gnt: got gnt(b,a)=%b%b, required %b", b_gnt_o, a_gnt_o, g);
    end
    #1;
    rst_ni = 0;
    idle_inputs();
    qa.delete(); qb.delete();
    exp_last_b = 1'b1;
    @(negedge clk);
    checks++;
    if (b_rvalid_o !== 1'b0 || sram_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rd_drop: got b_rvalid=%b sram_req=%b, required 0 0",
               b_rvalid_o, sram_req_o);
    end
    @(posedge clk); #1;
    rst_ni = 1;
`ifdef SRAM_CTRL_INIT_EN
    for (int i = 0; i <= 500; i++) begin
      @(negedge clk);
      checks++;
      if (b_rvalid_o !== 1'b0 || init_done_o !== 1'b0 || sram_addr_o !== AddrW'(i)) begin
        errors++;
        $display("FAIL reinit_a %0d: got rvalid=%b done=%b addr=%h, required 0 0 %h",
                 i, b_rvalid_o, init_done_o, sram_addr_o, AddrW'(i));
      end
    end
    #1;
    rst_ni = 0;
    #1;
    checks++;
    if (sram_req_o !== 1'b0 || sram_addr_o !== '0 || init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL init_async_reset: got req=%b addr=%h done=%b, required 0 000 0",
               sram_req_o, sram_addr_o, init_done_o);
    end
    @(posedge clk); #1;
    rst_ni = 1;
    for (int i = 0; i < Depth; i++) begin
      @(negedge clk);
      checks++;
      if (init_done_o !== 1'b0 || sram_req_o !== 1'b1 || sram_addr_o !== AddrW'(i)) begin
        errors++;
        $display("FAIL reinit_b %0d: got done=%b req=%b addr=%h, required 0 1 %h",
                 i, init_done_o, sram_req_o, sram_addr_o, AddrW'(i));
      end
    end
    @(negedge clk);
    checks++;
    if (init_done_o !== 1'b1) begin
      errors++;
      $display("FAIL reinit_done: got %b, required 1", init_done_o);
    end
    for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
    step();
    a_req = 1; a_write = 0; a_addr = 10'h200;
    @(negedge clk);
    g = exp_winner(1'b1, 1'b0);
    checks++;
    if ({b_gnt_o, a_gnt_o} !== g) begin
      errors++;
      $display("FAIL reinit_rd_gnt: got gnt(b,a)=%b%b, required %b", b_gnt_o, a_gnt_o, g);
    end
    record_grants();
    step();
    idle_inputs();
`else
    @(negedge clk);
    checks++;
    if (b_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rd_after: got b_rvalid=%b, required 0", b_rvalid_o);
    end
    step();
`endif
  endtask

  initial begin
    idle_inputs();
    exp_last_b = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
`ifdef SRAM_CTRL_INIT_EN
    test_init();
`else
    test_no_init();
`endif
    test_write_read();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d reads outstanding, required 0/0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
